bram_mem_requester: RTL
=======================

Name: bram_mem_requester

Overview:
- Initiator-side controller driving the single read port and single write port of the block RAM on behalf of the pipeline load/store unit.
- Accepts one byte-addressed load or store request at a time with sign/zero-extended loads.
- Performs read-modify-write for byte and halfword stores, because the RAM has no byte enables.
- Returns exactly one response per accepted request; flags misaligned accesses without touching the RAM.

Parameters:
ADDR_WIDTH, 8, RAM word-address width; byte address is ADDR_WIDTH+2 bits
DATA_WIDTH, 32, RAM word width; fixed at 32 (4 byte lanes)

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  controller idle, request accepted on req_valid&req_ready at posedge
req_write  in  1  1=store, 0=load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
req_addr  in  ADDR_WIDTH+2  byte address
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  one-cycle response pulse
resp_error  out  1  misaligned/illegal; valid with resp_valid
resp_rdata  out  32  load result; 0 for stores and errors
bram_readEnable  out  1  RAM read strobe
bram_readAddress  out  ADDR_WIDTH  RAM read word address
bram_readData  in  32  RAM read data, registered, valid the cycle after readEnable sampled
bram_writeEnable  out  1  RAM write strobe
bram_writeAddress  out  ADDR_WIDTH  RAM write word address
bram_writeData  out  32  RAM write data

Behaviour:
- All outputs are registered, except req_ready = (state==IDLE) & ~reset.
- Reset (sync): state IDLE; resp_valid, resp_error, bram_readEnable, bram_writeEnable = 0; all data/address outputs = 0.
- Word address = req_addr[ADDR_WIDTH+1:2]; lane = req_addr[1:0]. Request fields are latched at the acceptance edge E0.
- Misaligned: size 11; half with addr[0]=1; word with addr[1:0]!=0.
- States: IDLE, RD_ISSUE, RD_CAPTURE, WR_ISSUE, RESP.
- IDLE -> misaligned: RESP with resp_error=1, rdata=0; no RAM strobe ever raised.
- IDLE -> load, or byte/half store: RD_ISSUE; readEnable=1 and readAddress driven for exactly one cycle.
- IDLE -> word store: WR_ISSUE; writeEnable=1, writeAddress, writeData=req_wdata for exactly one cycle.
- RD_ISSUE -> RD_CAPTURE: readEnable=0.
- RD_CAPTURE, load: capture bram_readData at the edge, format it, go to RESP.
  - byte = word[8*lane+7:8*lane]; half = word[16*addr[1]+15:16*addr[1]].
  - Extend to 32 bits per req_unsigned.
- RD_CAPTURE, sub-word store: merge and go to WR_ISSUE.
  - byte replaces lane with wdata[7:0]; half replaces the addr[1] halfword with wdata[15:0]; other lanes are kept.
  - Same word address.
- WR_ISSUE -> RESP: writeEnable=0.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
- Latency from acceptance edge E0 (resp_valid high after edge En):
  - misaligned n=1
  - word store n=2
  - load n=3
  - sub-word store n=4
- req_ready returns one cycle after the response.
- No response backpressure. req_valid while busy is ignored, not queued.
- readEnable and writeEnable are never high in the same cycle.
- Reset mid-operation:
  - Abandons the request; no response is produced.
  - A writeEnable already high at the reset edge commits in the RAM. No strobe is issued after it.

Test Plan:
- Preload word 5=0x8899AABB; word load addr 0x14, unsigned=0 -> resp_valid after E3, rdata=0x8899AABB, error=0, readEnable high exactly 1 cycle with address 5.
- Byte load addr 0x17 signed -> 0xFFFFFF88. Byte addr 0x16 unsigned -> 0x00000099. Half addr 0x14 signed -> 0xFFFFAABB. Half addr 0x16 unsigned -> 0x00008899.
- From 0x8899AABB, byte store addr 0x15 wdata 0x12345677:
  - RAM word 5 = 0x889977BB.
  - One read then one write to address 5; write strobe after E2.
  - resp_valid after E4, rdata=0.
- Half store addr 0x16 wdata 0x0000CAFE -> word 5 = 0xCAFEAABB. Word store addr 0x14 wdata 0xDEADBEEF -> no read strobe, write after E0, resp after E2, reload reads 0xDEADBEEF.
- Misaligned word addr 0x16, half addr 0x13, size 11 -> resp_valid after E1, error=1, rdata=0, no RAM strobes, word 5 unchanged.
- Reset in RD_CAPTURE of a byte store:
  - No response and no write; word unchanged.
  - req_ready=1 the cycle after reset deasserts; the next word load completes normally.
  - req_valid held high throughout; only one request accepted per IDLE visit.

Source files
------------

// File: rtl/bram_mem_requester.sv
// bram_mem_requester
//   Load/store initiator for a block RAM that has one read port, one write
//   port and no byte enables. One request is accepted at a time. Byte and
//   halfword stores are done as read-modify-write. Every accepted request gets
//   exactly one response pulse. Misaligned or illegal requests are answered
//   with an error and never touch the RAM.
//
// Ports
//   clock, reset        rising-edge clock, synchronous active-high reset
//   req_*               request: valid/ready handshake, write, size, unsigned,
//                       byte address, right-aligned store data
//   resp_*              one-cycle response: valid, error, load data
//   bram_read*          read strobe, word address, registered read data
//   bram_write*         write strobe, word address, write data
module bram_mem_requester #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32   // fixed at four byte lanes
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [ADDR_WIDTH+1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   output logic                  resp_error,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  bram_readEnable,
   output logic [ADDR_WIDTH-1:0] bram_readAddress,
   input  logic [DATA_WIDTH-1:0] bram_readData,
   output logic                  bram_writeEnable,
   output logic [ADDR_WIDTH-1:0] bram_writeAddress,
   output logic [DATA_WIDTH-1:0] bram_writeData
);

   typedef enum logic [2:0] {
      IDLE,
      RD_ISSUE,
      RD_CAPTURE,
      WR_ISSUE,
      RESP
   } state_t;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   state_t                state;
   logic                  opWrite;
   logic [1:0]            opSize;
   logic                  opUnsigned;
   logic [1:0]            opLane;
   logic [ADDR_WIDTH-1:0] opWordAddr;
   logic [DATA_WIDTH-1:0] opWdata;
   logic                  opError;
   logic [DATA_WIDTH-1:0] loadResult;

   logic                  misaligned;
   logic                  wordStore;

   // Selects the addressed byte/halfword and extends it to a full word.
   function automatic logic [DATA_WIDTH-1:0] formatLoad(
      input logic [DATA_WIDTH-1:0] word,
      input logic [1:0]            size,
      input logic [1:0]            lane,
      input logic                  isUnsigned
   );
      logic [7:0]            b;
      logic [15:0]           h;
      logic [DATA_WIDTH-1:0] r;
      b = word[{lane, 3'b000} +: 8];
      h = word[{lane[1], 4'b0000} +: 16];
      // NOTE: every path through a combinational block or function assigns
      // the result, here via the default arm, so no latch is implied.
      case (size)
         SIZE_BYTE: r = {{24{~isUnsigned & b[7]}}, b};
         SIZE_HALF: r = {{16{~isUnsigned & h[15]}}, h};
         default:   r = word;
      endcase
      return r;
   endfunction

   // Replaces the addressed byte/halfword of the old word, keeping other lanes.
   function automatic logic [DATA_WIDTH-1:0] mergeStore(
      input logic [DATA_WIDTH-1:0] word,
      input logic [1:0]            size,
      input logic [1:0]            lane,
      input logic [DATA_WIDTH-1:0] wdata
   );
      logic [DATA_WIDTH-1:0] r;
      r = word;
      if (size == SIZE_BYTE) r[{lane, 3'b000} +: 8] = wdata[7:0];
      else                   r[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      return r;
   endfunction

   assign misaligned = (req_size == 2'b11)
                     | ((req_size == SIZE_HALF) & req_addr[0])
                     | ((req_size == SIZE_WORD) & (req_addr[1:0] != 2'b00));
   assign wordStore  = req_write & (req_size == SIZE_WORD);

   // The only unregistered output: reset must hold off acceptance at once.
   assign req_ready  = (state == IDLE) & ~reset;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         state             <= IDLE;
         opWrite           <= 1'b0;
         opSize            <= 2'b00;
         opUnsigned        <= 1'b0;
         opLane            <= 2'b00;
         opWordAddr        <= '0;
         opWdata           <= '0;
         opError           <= 1'b0;
         loadResult        <= '0;
         resp_valid        <= 1'b0;
         resp_error        <= 1'b0;
         resp_rdata        <= '0;
         bram_readEnable   <= 1'b0;
         bram_readAddress  <= '0;
         bram_writeEnable  <= 1'b0;
         bram_writeAddress <= '0;
         bram_writeData    <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req_valid) begin
                  opWrite    <= req_write;
                  opSize     <= req_size;
                  opUnsigned <= req_unsigned;
                  opLane     <= req_addr[1:0];
                  opWordAddr <= req_addr[ADDR_WIDTH+1:2];
                  opWdata    <= req_wdata;
                  opError    <= misaligned;
                  if (misaligned) begin
                     state <= RESP;
                  end else if (wordStore) begin
                     // Full-word store needs no read of the old contents.
                     bram_writeEnable  <= 1'b1;
                     bram_writeAddress <= req_addr[ADDR_WIDTH+1:2];
                     bram_writeData    <= req_wdata;
                     state             <= WR_ISSUE;
                  end else begin
                     bram_readEnable  <= 1'b1;
                     bram_readAddress <= req_addr[ADDR_WIDTH+1:2];
                     state            <= RD_ISSUE;
                  end
               end
            end
            RD_ISSUE: begin
               // RAM samples the strobe on this edge; data appears after it.
               bram_readEnable <= 1'b0;
               state           <= RD_CAPTURE;
            end
            RD_CAPTURE: begin
               if (opWrite) begin
                  bram_writeEnable  <= 1'b1;
                  bram_writeAddress <= opWordAddr;
                  bram_writeData    <= mergeStore(bram_readData, opSize, opLane, opWdata);
                  state             <= WR_ISSUE;
               end else begin
                  loadResult <= formatLoad(bram_readData, opSize, opLane, opUnsigned);
                  state      <= RESP;
               end
            end
            WR_ISSUE: begin
               bram_writeEnable <= 1'b0;
               state            <= RESP;
            end
            RESP: begin
               // First edge raises the response pulse, second retires it and
               // returns to IDLE, so req_ready follows the response by a cycle.
               if (!resp_valid) begin
                  resp_valid <= 1'b1;
                  resp_error <= opError;
                  resp_rdata <= (opWrite | opError) ? '0 : loadResult;
               end else begin
                  resp_valid <= 1'b0;
                  resp_error <= 1'b0;
                  resp_rdata <= '0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
